// File: rtl/bmp_gray_convert.sv
// bmp_gray_convert
//   Parses the BMP header held in the single-port image RAM and converts every
//   24-bpp pixel in place to grey, Y = (B + 2G + R) >> 2, written to B, G and R.
//   Row padding and header bytes are never written.
// Ports
//   clk       clock, all logic on posedge
//   rst_n     asynchronous active-low reset
//   in_valid  start request (sampled only in IDLE)
//   RAM_out   RAM read data, valid the cycle after RAM_ren
//   RAM_ren   RAM read strobe
//   RAM_wen   RAM write strobe (never together with RAM_ren)
//   RAM_addr  RAM byte address
//   RAM_in    RAM write data
//   done      conversion finished, held until reset
//   err       unsupported header (bpp != 24), set together with done
module bmp_gray_convert #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned HDR_BYTES  = 30
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [BYTE_WIDTH-1:0] RAM_out,
    output logic                  RAM_ren,
    output logic                  RAM_wen,
    output logic [ADDR_WIDTH-1:0] RAM_addr,
    output logic [BYTE_WIDTH-1:0] RAM_in,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned CNT_W = $clog2(HDR_BYTES + 1);
    localparam int unsigned FLD_W = 4 * BYTE_WIDTH;
    localparam int unsigned BPP_W = 2 * BYTE_WIDTH;
    localparam int unsigned SUM_W = BYTE_WIDTH + 2;
    localparam int unsigned PH_W  = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_CHECK,
        S_PIX,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FLD_W-1:0]      off_q, off_d;
    logic [FLD_W-1:0]      w_q, w_d;
    logic [FLD_W-1:0]      h_q, h_d;
    logic [BPP_W-1:0]      bpp_q, bpp_d;
    logic [FLD_W-1:0]      habs_q, habs_d;
    logic [1:0]            pad_q, pad_d;
    logic [FLD_W-1:0]      row_q, row_d;
    logic [FLD_W-1:0]      col_q, col_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [PH_W-1:0]       ph_q, ph_d;
    logic [BYTE_WIDTH-1:0] b_q, b_d;
    logic [BYTE_WIDTH-1:0] g_q, g_d;
    logic [BYTE_WIDTH-1:0] y_q, y_d;
    logic                  ren_q, ren_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BYTE_WIDTH-1:0] wdata_q, wdata_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [CNT_W-1:0]      hdr_idx;
    logic [FLD_W-1:0]      habs_c;
    logic [1:0]            w3_lo;
    logic [1:0]            pad_c;
    logic [SUM_W-1:0]      sum_c;
    logic [BYTE_WIDTH-1:0] y_c;

    // Byte arriving on RAM_out in HDR belongs to the read issued one cycle earlier.
    assign hdr_idx = cnt_q - CNT_W'(1);

    // Top-down images carry a negative height; only its magnitude matters here.
    assign habs_c = h_q[FLD_W-1] ? (~h_q + FLD_W'(1)) : h_q;

    // Padding = (-3W) mod 4, from the low two bits of 3W.
    assign w3_lo = 2'(w_q[1:0] + {w_q[0], 1'b0});
    assign pad_c = 2'(~w3_lo + 2'd1);

    // Grey value: R arrives on RAM_out in phase 3; 10-bit sum cannot overflow.
    assign sum_c = SUM_W'(b_q) + {1'b0, g_q, 1'b0} + SUM_W'(RAM_out);
    assign y_c   = sum_c[SUM_W-1:2];

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            off_q   <= '0;
            w_q     <= '0;
            h_q     <= '0;
            bpp_q   <= '0;
            habs_q  <= '0;
            pad_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            base_q  <= '0;
            ph_q    <= '0;
            b_q     <= '0;
            g_q     <= '0;
            y_q     <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            w_q     <= w_d;
            h_q     <= h_d;
            bpp_q   <= bpp_d;
            habs_q  <= habs_d;
            pad_q   <= pad_d;
            row_q   <= row_d;
            col_q   <= col_d;
            base_q  <= base_d;
            ph_q    <= ph_d;
            b_q     <= b_d;
            g_q     <= g_d;
            y_q     <= y_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next state; RAM strobes are computed for the coming cycle and registered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        w_d     = w_q;
        h_d     = h_q;
        bpp_d   = bpp_q;
        habs_d  = habs_q;
        pad_d   = pad_q;
        row_d   = row_q;
        col_d   = col_q;
        base_d  = base_q;
        ph_d    = ph_q;
        b_d     = b_q;
        g_d     = g_q;
        y_d     = y_q;
        ren_d   = 1'b0;
        wen_d   = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        done_d  = done_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_HDR;
                    cnt_d   = '0;
                    ren_d   = 1'b1;
                    addr_d  = '0;
                end
            end

            S_HDR: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q != '0) begin
                    case (hdr_idx)
                        CNT_W'(10): off_d[0*BYTE_WIDTH +: BYTE_WIDTH] = RAM_out;
                        CNT_W'(11): off_d[1*BYTE_WIDTH +: BYTE_WIDTH] = RAM_out;
                        CNT_W'(12): off_d[2*BYTE_WIDTH +: BYTE_WIDTH] = RAM_out;
                        CNT_W'(13): off_d[3*BYTE_WIDTH +: BYTE_WIDTH] = RAM_out;
                        CNT_W'(18): w_d[0*BYTE_WIDTH +: BYTE_WIDTH]   = RAM_out;
                        CNT_W'(19): w_d[1*BYTE_WIDTH +: BYTE_WIDTH]   = RAM_out;
                        CNT_W'(20): w_d[2*BYTE_WIDTH +: BYTE_WIDTH]   = RAM_out;
                        CNT_W'(21): w_d[3*BYTE_WIDTH +: BYTE_WIDTH]   = RAM_out;
                        CNT_W'(22): h_d[0*BYTE_WIDTH +: BYTE_WIDTH]   = RAM_out;
                        CNT_W'(23): h_d[1*BYTE_WIDTH +: BYTE_WIDTH]   = RAM_out;
                        CNT_W'(24): h_d[2*BYTE_WIDTH +: BYTE_WIDTH]   = RAM_out;
                        CNT_W'(25): h_d[3*BYTE_WIDTH +: BYTE_WIDTH]   = RAM_out;
                        CNT_W'(28): bpp_d[0*BYTE_WIDTH +: BYTE_WIDTH] = RAM_out;
                        CNT_W'(29): bpp_d[1*BYTE_WIDTH +: BYTE_WIDTH] = RAM_out;
                        default: ;
                    endcase
                end
                if (cnt_q == CNT_W'(HDR_BYTES)) begin
                    state_d = S_CHECK;
                    cnt_d   = '0;
                end else if (cnt_q < CNT_W'(HDR_BYTES - 1)) begin
                    ren_d  = 1'b1;
                    addr_d = ADDR_WIDTH'(cnt_d);
                end
            end

            S_CHECK: begin
                if (bpp_q != BPP_W'(24)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (w_q == '0 || habs_c == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_PIX;
                    habs_d  = habs_c;
                    pad_d   = pad_c;
                    row_d   = '0;
                    col_d   = '0;
                    ph_d    = '0;
                    base_d  = ADDR_WIDTH'(off_q);
                    ren_d   = 1'b1;
                    addr_d  = ADDR_WIDTH'(off_q);
                end
            end

            S_PIX: begin
                ph_d = ph_q + PH_W'(1);
                case (ph_q)
                    PH_W'(0): begin
                        ren_d  = 1'b1;
                        addr_d = base_q + ADDR_WIDTH'(1);
                    end
                    PH_W'(1): begin
                        b_d    = RAM_out;
                        ren_d  = 1'b1;
                        addr_d = base_q + ADDR_WIDTH'(2);
                    end
                    PH_W'(2): begin
                        g_d = RAM_out;
                    end
                    PH_W'(3): begin
                        y_d     = y_c;
                        wen_d   = 1'b1;
                        addr_d  = base_q;
                        wdata_d = y_c;
                    end
                    PH_W'(4): begin
                        wen_d   = 1'b1;
                        addr_d  = base_q + ADDR_WIDTH'(1);
                        wdata_d = y_q;
                    end
                    PH_W'(5): begin
                        wen_d   = 1'b1;
                        addr_d  = base_q + ADDR_WIDTH'(2);
                        wdata_d = y_q;
                    end
                    PH_W'(6): begin
                        ph_d = '0;
                        if (row_q == habs_q - FLD_W'(1) && col_q == w_q - FLD_W'(1)) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            // End of row skips the padding bytes.
                            if (col_q == w_q - FLD_W'(1)) begin
                                col_d  = '0;
                                row_d  = row_q + FLD_W'(1);
                                base_d = base_q + ADDR_WIDTH'(3) + ADDR_WIDTH'(pad_q);
                            end else begin
                                col_d  = col_q + FLD_W'(1);
                                base_d = base_q + ADDR_WIDTH'(3);
                            end
                            ren_d  = 1'b1;
                            addr_d = base_d;
                        end
                    end
                    default: ph_d = '0;
                endcase
            end

            S_DONE: ;

            default: state_d = S_IDLE;
        endcase
    end

    assign RAM_ren  = ren_q;
    assign RAM_wen  = wen_q;
    assign RAM_addr = addr_q;
    assign RAM_in   = wdata_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_bmp_gray_convert.sv
// tb_bmp_gray_convert
//   Directed bench for bmp_gray_convert: a byte RAM model, an image-level
//   reference (expected final RAM contents and writable byte map per job) and
//   a per-cycle check of every RAM write against that reference.
module tb_bmp_gray_convert;

    localparam int unsigned AW  = 20;
    localparam int unsigned BW  = 8;
    localparam int unsigned MEM = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [BW-1:0] RAM_out;
    logic          RAM_ren;
    logic          RAM_wen;
    logic [AW-1:0] RAM_addr;
    logic [BW-1:0] RAM_in;
    logic          done;
    logic          err;

    bmp_gray_convert dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .RAM_out  (RAM_out),
        .RAM_ren  (RAM_ren),
        .RAM_wen  (RAM_wen),
        .RAM_addr (RAM_addr),
        .RAM_in   (RAM_in),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Single-port byte RAM with a bench preload port.
    logic [7:0] mem [MEM];
    logic       pl_en = 1'b0;
    logic [7:0] pl_addr, pl_data;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (RAM_wen && RAM_addr < AW'(MEM)) mem[RAM_addr[7:0]] <= RAM_in;
        if (RAM_ren) RAM_out <= (RAM_addr < AW'(MEM)) ? mem[RAM_addr[7:0]] : 8'h00;
    end

    logic [7:0] img  [MEM];
    logic [7:0] expm [MEM];
    bit         mask [MEM];
    int checks = 0, passed = 0, wr_cnt = 0;
    bit mon = 1'b0;
    int cur_off, cur_w, cur_h, cur_bpp;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // One clock; outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (mon) begin
            if (RAM_ren || RAM_wen) chk("ren_wen_exclusive", 64'(RAM_ren & RAM_wen), 0);
            if (RAM_wen) begin
                wr_cnt++;
                if (RAM_addr >= AW'(MEM)) chk("write_addr_range", 64'(RAM_addr), 0);
                else begin
                    chk("write_in_pixel_area", 64'(mask[RAM_addr[7:0]]), 1);
                    chk("write_data", 64'(RAM_in), 64'(expm[RAM_addr[7:0]]));
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic preload();
        for (int i = 0; i < MEM; i++) begin
            pl_en   = 1'b1;
            pl_addr = 8'(i);
            pl_data = img[i];
            step();
        end
        pl_en = 1'b0;
    endtask

    task automatic put_le(input int a, input int v, input int nbytes);
        logic [31:0] x;
        x = v;
        for (int k = 0; k < nbytes; k++) img[a+k] = x[8*k +: 8];
    endtask

    task automatic build_img(input int off, input int w, input int h, input int bpp);
        for (int i = 0; i < MEM; i++) img[i] = 8'(i * 37 + 11);
        img[0] = 8'h42;
        img[1] = 8'h4D;
        cur_off = off; cur_w = w; cur_h = h; cur_bpp = bpp;
        put_le(10, off, 4);
        put_le(18, w, 4);
        put_le(22, h, 4);
        put_le(28, bpp, 2);
    endtask

    function automatic int stride_of(input int w);
        return ((3 * w + 3) / 4) * 4;
    endfunction

    task automatic set_px(input int r, input int c, input int b, input int g, input int rr);
        int a;
        a = cur_off + r * stride_of(cur_w) + 3 * c;
        img[a]   = 8'(b);
        img[a+1] = 8'(g);
        img[a+2] = 8'(rr);
    endtask

    // Reference: each pixel of the image in img becomes (B + 2G + R) / 4.
    task automatic model();
        int habs, a, y;
        for (int i = 0; i < MEM; i++) begin
            expm[i] = img[i];
            mask[i] = 1'b0;
        end
        habs = (cur_h < 0) ? -cur_h : cur_h;
        if (cur_bpp == 24 && cur_w != 0 && habs != 0) begin
            for (int r = 0; r < habs; r++) begin
                for (int c = 0; c < cur_w; c++) begin
                    a = cur_off + r * stride_of(cur_w) + 3 * c;
                    y = (int'(img[a]) + 2 * int'(img[a+1]) + int'(img[a+2])) / 4;
                    for (int k = 0; k < 3; k++) begin
                        expm[a+k] = 8'(y);
                        mask[a+k] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic start_job();
        do_reset();
        preload();
        model();
        wr_cnt   = 0;
        mon      = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input int exp_err, input int exp_wr);
        int n;
        int bad;
        bit seen;
        n = 0; bad = 0; seen = 1'b0;
        for (int i = 1; i <= exp_lat + 40 && !seen; i++) begin
            step();
            if (done) begin
                seen = 1'b1;
                n = i;
            end
        end
        if (!seen) chk({tag, "_done_timeout"}, 0, 1);
        else chk({tag, "_done_latency"}, n, exp_lat);
        chk({tag, "_err"}, 64'(err), exp_err);
        chk({tag, "_write_count"}, wr_cnt, exp_wr);
        for (int i = 0; i < MEM; i++) if (mem[i] !== expm[i]) bad++;
        chk({tag, "_final_image_bad_bytes"}, bad, 0);
    endtask

    initial begin
        int hb;
        rst_n = 1'b1;
        in_valid = 1'b0;

        // Reset state
        do_reset();
        chk("rst_ren", 64'(RAM_ren), 0);
        chk("rst_wen", 64'(RAM_wen), 0);
        chk("rst_addr", 64'(RAM_addr), 0);
        chk("rst_in", 64'(RAM_in), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_err", 64'(err), 0);

        // 2x2 uniform image with padding
        build_img(54, 2, 2, 24);
        for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) set_px(r, c, 10, 20, 30);
        start_job();
        wait_done("s1", 60, 0, 12);
        chk("s1_lit_54", 64'(mem[54]), 20);
        chk("s1_lit_59", 64'(mem[59]), 20);
        chk("s1_lit_67", 64'(mem[67]), 20);
        chk("s1_pad_60", 64'(mem[60]), 64'(img[60]));
        chk("s1_pad_61", 64'(mem[61]), 64'(img[61]));
        chk("s1_pad_68", 64'(mem[68]), 64'(img[68]));
        chk("s1_pad_69", 64'(mem[69]), 64'(img[69]));
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 40; i++) step();
        chk("s1_done_held", 64'(done), 1);
        chk("s1_no_restart_writes", wr_cnt, 12);

        // Saturation and truncation corner pixels
        build_img(54, 2, 1, 24);
        set_px(0, 0, 255, 255, 255);
        set_px(0, 1, 1, 0, 2);
        start_job();
        wait_done("s2", 46, 0, 6);
        chk("s2_lit_white_b", 64'(mem[54]), 255);
        chk("s2_lit_white_r", 64'(mem[56]), 255);
        chk("s2_lit_trunc_b", 64'(mem[57]), 0);
        chk("s2_lit_trunc_r", 64'(mem[59]), 0);

        // 4x1, no padding; header untouched
        build_img(54, 4, 1, 24);
        for (int c = 0; c < 4; c++) set_px(0, c, 10 * c + 1, 50 + c, 200 - c);
        start_job();
        wait_done("s3", 60, 0, 12);
        chk("s3_lit_px0", 64'(mem[54]), 75);
        chk("s3_lit_px3", 64'(mem[65]), 83);
        hb = 0;
        for (int i = 0; i < 54; i++) if (mem[i] !== img[i]) hb++;
        chk("s3_header_changed_bytes", hb, 0);

        // 3x2 with 3 padding bytes per row
        build_img(54, 3, 2, 24);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++) set_px(r, c, c * 60 + r * 5, 255 - c * 30, r * 100 + c);
        start_job();
        wait_done("s3b", 74, 0, 18);

        // Unsupported bpp
        build_img(54, 2, 2, 32);
        start_job();
        wait_done("s4", 32, 1, 0);

        // Zero width
        build_img(54, 0, 2, 24);
        start_job();
        wait_done("s4b", 32, 0, 0);

        // Top-down (negative height)
        build_img(54, 2, -2, 24);
        for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) set_px(r, c, 10, 20, 30);
        start_job();
        wait_done("s5", 60, 0, 12);
        chk("s5_lit_54", 64'(mem[54]), 20);
        chk("s5_lit_67", 64'(mem[67]), 20);

        // Reset during the second write of the first pixel, then rerun
        build_img(54, 2, 2, 24);
        for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) set_px(r, c, 40, 100, 200);
        start_job();
        for (int i = 1; i <= 37; i++) step();
        chk("s6_c5_wen", 64'(RAM_wen), 1);
        chk("s6_c5_addr", 64'(RAM_addr), 55);
        rst_n = 1'b0;
        #1;
        chk("s6_rst_wen", 64'(RAM_wen), 0);
        chk("s6_rst_ren", 64'(RAM_ren), 0);
        chk("s6_rst_addr", 64'(RAM_addr), 0);
        chk("s6_rst_in", 64'(RAM_in), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("s6_abort_b", 64'(mem[54]), 110);
        chk("s6_abort_g", 64'(mem[55]), 100);
        chk("s6_abort_r", 64'(mem[56]), 200);
        chk("s6_abort_px1", 64'(mem[57]), 40);
        for (int i = 0; i < MEM; i++) img[i] = mem[i];
        start_job();
        wait_done("s6", 60, 0, 12);
        chk("s6_lit_b", 64'(mem[54]), 127);
        chk("s6_lit_g", 64'(mem[55]), 127);
        chk("s6_lit_r", 64'(mem[56]), 127);
        chk("s6_lit_px1", 64'(mem[57]), 110);

        mon = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
